snn_spike_encoder: RTL and testbench

Front-end stage of the reflex path: accepts signed sensor sample pairs over a valid/ready handshake and converts them into the three single-cycle spike trains consumed by the SNN reflex neuron: drift, spread and shock. Each channel compares a derived magnitude against a programmable threshold. Each channel has a per-channel refractory counter, so a sustained condition produces a spike rate rather than a constant level.

---
 rtl/snn_spike_encoder_if.sv | 34 +++
 rtl/snn_spike_encoder.sv | 243 ++++++++++++++++++++++++
 tb/tb_snn_spike_encoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/snn_spike_encoder_if.sv
// ---------------------------------------------------------------------------
// snn_spike_encoder_if
//   Sample handshake bundle between the sensor front end and the spike
//   encoder. One transfer happens on a rising clock edge where both
//   sample_valid and sample_ready are high.
//
//   sample_valid  producer -> encoder  sample pair offered
//   sample_ready  encoder  -> producer encoder can accept a sample
//   sample_a      producer -> encoder  primary sensor, signed 16b
//   sample_b      producer -> encoder  secondary sensor, signed 16b
//
//   master : sample producer
//   slave  : spike encoder
// ---------------------------------------------------------------------------
interface snn_spike_encoder_if;
    logic               sample_valid;
    logic               sample_ready;
    logic signed [15:0] sample_a;
    logic signed [15:0] sample_b;

    modport master (
        output sample_valid,
        output sample_a,
        output sample_b,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_a,
        input  sample_b,
        output sample_ready
    );
endinterface

// File: rtl/snn_spike_encoder.sv
// ---------------------------------------------------------------------------
// snn_spike_encoder
//   Reflex-path front end. Takes signed sensor sample pairs over a
//   valid/ready handshake and produces three single-cycle spike trains:
//     drift  : |a - baseline| > drift_thresh   (baseline = EMA of a)
//     spread : |a - b|        > spread_thresh
//     shock  : |a - a_prev|   > shock_thresh
//   Each channel has its own refractory counter (counted in samples) so a
//   sustained condition yields a spike rate instead of a level.
//
//   Sample flow: IDLE (accept) -> CALC (magnitudes) -> FIRE (compare,
//   refractory, history update) -> IDLE. One sample every 3 cycles.
//
//   Ports
//     clk, rst        clock (rising), asynchronous active-high reset
//     smp             sample handshake (slave side)
//     shock_thresh    unsigned threshold, shock channel
//     drift_thresh    unsigned threshold, drift channel
//     spread_thresh   unsigned threshold, spread channel
//     refractory      samples suppressed after a channel fires (0 = none)
//     spike_drift     one-cycle spike pulse
//     spike_spread    one-cycle spike pulse
//     spike_shock     one-cycle spike pulse
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// snn_enc_chan
//   One spike channel: strict threshold compare gated by a refractory
//   counter. Evaluated only on the FIRE cycle; hold_i freezes the channel
//   (no fire, counter untouched), used while history is being primed.
//
//   Ports
//     clk, rst        clock, asynchronous active-high reset
//     eval_i          FIRE cycle strobe
//     hold_i          suppress this evaluation entirely
//     mag_i           17-bit unsigned magnitude
//     thresh_i        16-bit unsigned threshold
//     refractory_i    reload value for the refractory counter
//     spike_o         registered one-cycle spike
// ---------------------------------------------------------------------------
module snn_enc_chan #(
    parameter int REFRACT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 eval_i,
    input  logic                 hold_i,
    input  logic [16:0]          mag_i,
    input  logic [15:0]          thresh_i,
    input  logic [REFRACT_W-1:0] refractory_i,
    output logic                 spike_o
);
    logic [REFRACT_W-1:0] refr_q, refr_d;
    logic                 spike_q, spike_d;
    logic                 fire;

    always_comb begin
        fire    = eval_i && !hold_i && (refr_q == '0) && (mag_i > {1'b0, thresh_i});
        refr_d  = refr_q;
        spike_d = fire;
        if (eval_i && !hold_i) begin
            if (fire)
                refr_d = refractory_i;
            else if (refr_q != '0)
                refr_d = refr_q - REFRACT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refr_q  <= '0;
            spike_q <= 1'b0;
        end else begin
            refr_q  <= refr_d;
            spike_q <= spike_d;
        end
    end

    assign spike_o = spike_q;
endmodule

module snn_spike_encoder #(
    parameter int EMA_SHIFT = 4,
    parameter int REFRACT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    snn_spike_encoder_if.slave   smp,
    input  logic [15:0]          shock_thresh,
    input  logic [15:0]          drift_thresh,
    input  logic [15:0]          spread_thresh,
    input  logic [REFRACT_W-1:0] refractory,
    output logic                 spike_drift,
    output logic                 spike_spread,
    output logic                 spike_shock
);
    localparam int NUM_CH = 3;
    localparam int CH_DRIFT  = 0;
    localparam int CH_SPREAD = 1;
    localparam int CH_SHOCK  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIRE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        ready_q, ready_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] base_q, base_d;
    logic        primed_q, primed_d;

    logic [NUM_CH-1:0][16:0] mag_q, mag_d;
    logic [NUM_CH-1:0][15:0] thresh;
    logic [NUM_CH-1:0]       hold;
    logic [NUM_CH-1:0]       spike;

    logic        accept;
    logic [16:0] ema_diff;

    // |x - y| of two signed 16-bit values; the 17-bit difference cannot
    // overflow and its two's-complement negation fits 17 unsigned bits.
    function automatic logic [16:0] absdiff(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] d;
        d = {x[15], x} - {y[15], y};
        return d[16] ? (~d + 17'd1) : d;
    endfunction

    assign accept = (state_q == IDLE) && smp.sample_valid;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    state_d = FIRE;
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // ready is registered: high exactly while the next state is IDLE
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // ---------------- datapath ----------------
    // Baseline step difference; arithmetic shift rounds toward -inf, and
    // the updated baseline lies between old baseline and a, so the low
    // 16 bits of the sum are exact.
    assign ema_diff = {a_q[15], a_q} - {base_q[15], base_q};

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        prev_d   = prev_q;
        base_d   = base_q;
        primed_d = primed_q;
        mag_d    = mag_q;

        if (accept) begin
            a_d = smp.sample_a;
            b_d = smp.sample_b;
        end

        if (state_q == CALC) begin
            mag_d[CH_DRIFT]  = absdiff(a_q, base_q);
            mag_d[CH_SPREAD] = absdiff(a_q, b_q);
            mag_d[CH_SHOCK]  = absdiff(a_q, prev_q);
        end

        if (state_q == FIRE) begin
            prev_d   = a_q;
            primed_d = 1'b1;
            // first sample seeds the baseline directly instead of filtering
            if (primed_q)
                base_d = base_q + 16'($signed(ema_diff) >>> EMA_SHIFT);
            else
                base_d = a_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            prev_q   <= '0;
            base_q   <= '0;
            primed_q <= 1'b0;
            mag_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            prev_q   <= prev_d;
            base_q   <= base_d;
            primed_q <= primed_d;
            mag_q    <= mag_d;
        end
    end

    // ---------------- channels ----------------
    // Shock and drift compare against history, which is meaningless until
    // the first sample has been seen; spread needs no history.
    always_comb begin
        thresh[CH_DRIFT]  = drift_thresh;
        thresh[CH_SPREAD] = spread_thresh;
        thresh[CH_SHOCK]  = shock_thresh;
        hold[CH_DRIFT]    = !primed_q;
        hold[CH_SPREAD]   = 1'b0;
        hold[CH_SHOCK]    = !primed_q;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        snn_enc_chan #(
            .REFRACT_W (REFRACT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .eval_i       (state_q == FIRE),
            .hold_i       (hold[c]),
            .mag_i        (mag_q[c]),
            .thresh_i     (thresh[c]),
            .refractory_i (refractory),
            .spike_o      (spike[c])
        );
    end

    assign smp.sample_ready = ready_q;
    assign spike_drift      = spike[CH_DRIFT];
    assign spike_spread     = spike[CH_SPREAD];
    assign spike_shock      = spike[CH_SHOCK];
endmodule

// File: tb/tb_snn_spike_encoder.sv
// ---------------------------------------------------------------------------
// tb_snn_spike_encoder
//   Directed-vector bench for snn_spike_encoder. Spike vectors are packed
//   {shock, spread, drift}.
// ---------------------------------------------------------------------------
module tb_snn_spike_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] shock_thresh, drift_thresh, spread_thresh;
    logic [7:0]  refractory;
    logic        spike_drift, spike_spread, spike_shock;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snn_spike_encoder_if sif ();

    snn_spike_encoder #(
        .EMA_SHIFT (4),
        .REFRACT_W (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .smp           (sif.slave),
        .shock_thresh  (shock_thresh),
        .drift_thresh  (drift_thresh),
        .spread_thresh (spread_thresh),
        .refractory    (refractory),
        .spike_drift   (spike_drift),
        .spike_spread  (spike_spread),
        .spike_shock   (spike_shock)
    );

    function automatic logic [2:0] spikes();
        return {spike_shock, spike_spread, spike_drift};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sif.sample_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one sample, check the 3-cycle handshake timing and compare the
    // spike vector seen in the cycle after FIRE against exp. During the busy
    // cycles valid is held high with junk data, which must be ignored.
    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] exp);
        @(negedge clk);
        chk({tag, ".ready_before"}, 32'(sif.sample_ready), 32'd1);
        sif.sample_valid = 1'b1;
        sif.sample_a     = a;
        sif.sample_b     = b;
        @(posedge clk);
        #1;
        sif.sample_a = 16'h7fff;
        sif.sample_b = 16'h8000;
        @(negedge clk);
        chk({tag, ".busy1"}, {29'd0, spikes()} | {31'd0, sif.sample_ready} << 4, 32'd0);
        @(negedge clk);
        chk({tag, ".busy2"}, {29'd0, spikes()} | {31'd0, sif.sample_ready} << 4, 32'd0);
        sif.sample_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".ready_after"}, 32'(sif.sample_ready), 32'd1);
        chk({tag, ".spikes"}, 32'(spikes()), 32'(exp));
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(spikes()), 32'd0);
    endtask

    initial begin
        sif.sample_valid = 1'b0;
        sif.sample_a     = '0;
        sif.sample_b     = '0;
        shock_thresh     = 16'd100;
        drift_thresh     = 16'd100;
        spread_thresh    = 16'd100;
        refractory       = 8'd0;
        rst              = 1'b0;

        // reset state
        do_reset();
        chk("reset.ready", 32'(sif.sample_ready), 32'd1);
        chk("reset.spikes", 32'(spikes()), 32'd0);

        // priming: history-based channels stay quiet, spread |0| <= 100
        send("prime", 16'd1000, 16'd1000, 3'b000);

        // shock: |3000-1000| = 2000 > 1500; drift 2000 <= 5000; spread 0
        shock_thresh = 16'd1500;
        drift_thresh = 16'd5000;
        send("shock", 16'd3000, 16'd3000, 3'b100);

        // spread strict compare: |1000 - (-1000)| = 2000
        shock_thresh  = 16'd30000;
        drift_thresh  = 16'd30000;
        spread_thresh = 16'd1999;
        send("spread_1999", 16'd1000, -16'sd1000, 3'b010);
        spread_thresh = 16'd2000;
        send("spread_2000", 16'd1000, -16'sd1000, 3'b000);

        // drift / EMA: baseline 0 -> 50 -> 96 -> 140, mags 800,750,704,660
        do_reset();
        shock_thresh  = 16'd60000;
        spread_thresh = 16'd60000;
        drift_thresh  = 16'd700;
        refractory    = 8'd0;
        send("drift_prime", 16'd0, 16'd0, 3'b000);
        send("drift_s2", 16'd800, 16'd800, 3'b001);
        send("drift_s3", 16'd800, 16'd800, 3'b001);
        send("drift_s4", 16'd800, 16'd800, 3'b001);
        send("drift_s5", 16'd800, 16'd800, 3'b000);

        // refractory = 2: delta is 3000 every sample, fires on 1, 4, 7
        do_reset();
        shock_thresh  = 16'd1500;
        drift_thresh  = 16'd60000;
        spread_thresh = 16'd60000;
        refractory    = 8'd2;
        send("refr_prime", 16'd0, 16'd0, 3'b000);
        for (int i = 1; i <= 8; i++) begin
            logic [15:0] av;
            av = (i % 2 == 1) ? 16'd3000 : 16'd0;
            send($sformatf("refr_s%0d", i), av, av,
                 (i == 1 || i == 4 || i == 7) ? 3'b100 : 3'b000);
        end

        // reset during CALC of a shock-qualifying sample (prev = 0)
        refractory = 8'd0;
        @(negedge clk);
        sif.sample_valid = 1'b1;
        sif.sample_a     = 16'd5000;
        sif.sample_b     = 16'd5000;
        @(posedge clk);
        #1;
        sif.sample_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.ready", 32'(sif.sample_ready), 32'd1);
        chk("midrst.spikes", 32'(spikes()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst.quiet%0d", i), 32'(spikes()), 32'd0);
        end
        chk("midrst.ready_after", 32'(sif.sample_ready), 32'd1);
        // primed was cleared: a large delta is only a priming sample
        send("midrst_prime", 16'd20000, 16'd20000, 3'b000);
        // history now valid: |0-20000| > 1500 shock; drift 20000 <= 60000
        send("midrst_next", 16'd0, 16'd0, 3'b100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
